// File: rtl/writeback_queue.sv
// Write-back staging FIFO in front of the register bank: buffers (addr, data) requests,
// drains one per cycle as a registered one-hot strobe, and forwards pending values.
module writeback_queue #(
  parameter int DATA_SIZE    = 32,
  parameter int ADDR_SIZE    = 5,
  parameter int DEPTH        = 4,
  parameter bit ZERO_DISCARD = 1'b1,
  localparam int REG_COUNT   = 2 ** ADDR_SIZE,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [ADDR_SIZE-1:0] IN_ADDR,
  input  logic [DATA_SIZE-1:0] IN_DATA,
  input  logic                 STALL_DRAIN,
  output logic [REG_COUNT-1:0] OUT_WRITE,
  output logic [DATA_SIZE-1:0] OUT_DATA,
  input  logic [ADDR_SIZE-1:0] LOOKUP_ADDR,
  output logic                 LOOKUP_HIT,
  output logic [DATA_SIZE-1:0] LOOKUP_DATA,
  output logic [CNT_W-1:0]     COUNT
);

  function automatic logic is_discarded(input logic [ADDR_SIZE-1:0] addr);
    return ZERO_DISCARD && (addr == {ADDR_SIZE{1'b0}});
  endfunction

  logic [ADDR_SIZE-1:0] addr_mem_q [DEPTH];
  logic [DATA_SIZE-1:0] data_mem_q [DEPTH];
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 out_vld_q, out_vld_d;
  logic [ADDR_SIZE-1:0] out_addr_q, out_addr_d;
  logic [REG_COUNT-1:0] out_write_q, out_write_d;
  logic [DATA_SIZE-1:0] out_data_q, out_data_d;
  logic                 in_ready_s, push_s, pop_s;
  logic [ADDR_SIZE-1:0] head_addr_s;
  logic                 hit_s;
  logic [DATA_SIZE-1:0] hit_data_s;

  // Ready comes from registered occupancy only, so a full queue never accepts even while popping.
  assign in_ready_s  = RST & (count_q < CNT_W'(DEPTH));
  assign push_s      = IN_VALID & in_ready_s;
  assign pop_s       = (count_q != {CNT_W{1'b0}}) & ~STALL_DRAIN;
  assign head_addr_s = addr_mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy, valid bits and the output stage.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    vld_d       = vld_q;
    count_d     = count_q;
    out_vld_d   = 1'b0;
    out_addr_d  = out_addr_q;
    out_write_d = {REG_COUNT{1'b0}};
    out_data_d  = out_data_q;
    if (push_s) begin
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      vld_d[wr_ptr_q] = 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
      vld_d[rd_ptr_q] = 1'b0;
      out_vld_d       = 1'b1;
      out_addr_d      = head_addr_s;
      out_data_d      = data_mem_q[rd_ptr_q];
      if (is_discarded(head_addr_s)) begin
        out_write_d = {REG_COUNT{1'b0}};
      end else begin
        out_write_d = {{(REG_COUNT-1){1'b0}}, 1'b1} << head_addr_s;
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state and output stage, cleared asynchronously so an in-flight strobe drops at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      vld_q       <= {DEPTH{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      out_vld_q   <= 1'b0;
      out_addr_q  <= {ADDR_SIZE{1'b0}};
      out_write_q <= {REG_COUNT{1'b0}};
      out_data_q  <= {DATA_SIZE{1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      vld_q       <= vld_d;
      count_q     <= count_d;
      out_vld_q   <= out_vld_d;
      out_addr_q  <= out_addr_d;
      out_write_q <= out_write_d;
      out_data_q  <= out_data_d;
    end
  end

  // Entry storage; validity is tracked by vld_q, so the payload needs no reset.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      addr_mem_q[wr_ptr_q] <= IN_ADDR;
      data_mem_q[wr_ptr_q] <= IN_DATA;
    end
  end

  // Forwarding search: output stage is oldest, then FIFO entries head to tail; youngest match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = {PTR_W{1'b0}};
    hit_s      = 1'b0;
    hit_data_s = {DATA_SIZE{1'b0}};
    if (out_vld_q && (out_addr_q == LOOKUP_ADDR)) begin
      hit_s      = 1'b1;
      hit_data_s = out_data_q;
    end else begin
      hit_s = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && vld_q[idx] && (addr_mem_q[idx] == LOOKUP_ADDR)) begin
        hit_s      = 1'b1;
        hit_data_s = data_mem_q[idx];
      end else begin
        hit_data_s = hit_data_s;
      end
    end
    if (is_discarded(LOOKUP_ADDR)) begin
      hit_s      = 1'b0;
      hit_data_s = {DATA_SIZE{1'b0}};
    end else begin
      hit_s = hit_s;
    end
  end

  assign IN_READY    = in_ready_s;
  assign OUT_WRITE   = out_write_q;
  assign OUT_DATA    = out_data_q;
  assign LOOKUP_HIT  = hit_s;
  assign LOOKUP_DATA = hit_data_s;
  assign COUNT       = count_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue; inputs change and outputs are sampled at negedge.
module tb_writeback_queue;

  logic        CLK;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [4:0]  IN_ADDR;
  logic [31:0] IN_DATA;
  logic        STALL_DRAIN;
  logic [31:0] OUT_WRITE;
  logic [31:0] OUT_DATA;
  logic [4:0]  LOOKUP_ADDR;
  logic        LOOKUP_HIT;
  logic [31:0] LOOKUP_DATA;
  logic [2:0]  COUNT;

  int pass_cnt = 0;
  int total_cnt = 0;

  writeback_queue dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_ADDR(IN_ADDR), .IN_DATA(IN_DATA), .STALL_DRAIN(STALL_DRAIN),
    .OUT_WRITE(OUT_WRITE), .OUT_DATA(OUT_DATA), .LOOKUP_ADDR(LOOKUP_ADDR),
    .LOOKUP_HIT(LOOKUP_HIT), .LOOKUP_DATA(LOOKUP_DATA), .COUNT(COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b0; IN_VALID = 1'b0; IN_ADDR = 5'd0; IN_DATA = 32'd0;
    STALL_DRAIN = 1'b0; LOOKUP_ADDR = 5'd31;
    step(); step();
    total_cnt++; if (IN_READY !== 1'b0) $display("FAIL reset_ready got %0b want 0", IN_READY); else pass_cnt++;
    total_cnt++; if (COUNT !== 3'd0) $display("FAIL reset_count got %0d want 0", COUNT); else pass_cnt++;
    total_cnt++; if (OUT_WRITE !== 32'd0) $display("FAIL reset_write got %h want 0", OUT_WRITE); else pass_cnt++;
    total_cnt++; if (OUT_DATA !== 32'd0) $display("FAIL reset_data got %h want 0", OUT_DATA); else pass_cnt++;
    RST = 1'b1;
    #1;
    total_cnt++; if (IN_READY !== 1'b1) $display("FAIL release_ready got %0b want 1", IN_READY); else pass_cnt++;
  endtask

  task automatic test_single();
    IN_VALID = 1'b1; IN_ADDR = 5'd3; IN_DATA = 32'hDEADBEEF;
    step();
    IN_VALID = 1'b0;
    total_cnt++; if (COUNT !== 3'd1) $display("FAIL single_count1 got %0d want 1", COUNT); else pass_cnt++;
    total_cnt++; if (OUT_WRITE !== 32'd0) $display("FAIL single_early got %h want 0", OUT_WRITE); else pass_cnt++;
    step();
    total_cnt++; if (COUNT !== 3'd0) $display("FAIL single_count0 got %0d want 0", COUNT); else pass_cnt++;
    total_cnt++; if (OUT_WRITE !== 32'h0000_0008) $display("FAIL single_write got %h want 00000008", OUT_WRITE); else pass_cnt++;
    total_cnt++; if (OUT_DATA !== 32'hDEADBEEF) $display("FAIL single_data got %h want deadbeef", OUT_DATA); else pass_cnt++;
    step();
    total_cnt++; if (OUT_WRITE !== 32'd0) $display("FAIL single_once got %h want 0", OUT_WRITE); else pass_cnt++;
    total_cnt++; if (OUT_DATA !== 32'hDEADBEEF) $display("FAIL single_hold got %h want deadbeef", OUT_DATA); else pass_cnt++;
  endtask

  task automatic test_full_wrap();
    STALL_DRAIN = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      IN_VALID = 1'b1; IN_ADDR = 5'(i); IN_DATA = 32'h100 + 32'(i);
      step();
      total_cnt++; if (COUNT !== 3'(i)) $display("FAIL fill_count got %0d want %0d", COUNT, i); else pass_cnt++;
    end
    IN_ADDR = 5'd5; IN_DATA = 32'h105;
    #1;
    total_cnt++; if (IN_READY !== 1'b0) $display("FAIL full_ready got %0b want 0", IN_READY); else pass_cnt++;
    step();
    total_cnt++; if (COUNT !== 3'd4) $display("FAIL full_hold got %0d want 4", COUNT); else pass_cnt++;
    STALL_DRAIN = 1'b0;
    step();
    total_cnt++; if (COUNT !== 3'd3) $display("FAIL pop1_count got %0d want 3", COUNT); else pass_cnt++;
    total_cnt++; if (OUT_WRITE !== 32'h2) $display("FAIL pop1_write got %h want 2", OUT_WRITE); else pass_cnt++;
    total_cnt++; if (IN_READY !== 1'b1) $display("FAIL pop1_ready got %0b want 1", IN_READY); else pass_cnt++;
    step();
    IN_VALID = 1'b0;
    total_cnt++; if (COUNT !== 3'd3) $display("FAIL pop2_count got %0d want 3", COUNT); else pass_cnt++;
    for (int i = 2; i <= 5; i++) begin
      if (i > 2) step();
      total_cnt++; if (OUT_WRITE !== (32'd1 << i)) $display("FAIL drain_write got %h want %h", OUT_WRITE, 32'd1 << i); else pass_cnt++;
      total_cnt++; if (OUT_DATA !== 32'h100 + 32'(i)) $display("FAIL drain_data got %h want %h", OUT_DATA, 32'h100 + 32'(i)); else pass_cnt++;
    end
    total_cnt++; if (COUNT !== 3'd0) $display("FAIL drain_count got %0d want 0", COUNT); else pass_cnt++;
    step();
    total_cnt++; if (OUT_WRITE !== 32'd0) $display("FAIL drain_idle got %h want 0", OUT_WRITE); else pass_cnt++;
  endtask

  task automatic test_lookup();
    STALL_DRAIN = 1'b1;
    IN_VALID = 1'b1; IN_ADDR = 5'd7; IN_DATA = 32'h11;
    step();
    IN_DATA = 32'h22;
    step();
    IN_VALID = 1'b0; LOOKUP_ADDR = 5'd7;
    #1;
    total_cnt++; if (LOOKUP_HIT !== 1'b1) $display("FAIL lk7_hit got %0b want 1", LOOKUP_HIT); else pass_cnt++;
    total_cnt++; if (LOOKUP_DATA !== 32'h22) $display("FAIL lk7_data got %h want 22", LOOKUP_DATA); else pass_cnt++;
    LOOKUP_ADDR = 5'd8;
    #1;
    total_cnt++; if (LOOKUP_HIT !== 1'b0) $display("FAIL lk8_hit got %0b want 0", LOOKUP_HIT); else pass_cnt++;
    total_cnt++; if (LOOKUP_DATA !== 32'h0) $display("FAIL lk8_data got %h want 0", LOOKUP_DATA); else pass_cnt++;
    LOOKUP_ADDR = 5'd7; STALL_DRAIN = 1'b0;
    step();
    total_cnt++; if (OUT_WRITE !== 32'h80 || OUT_DATA !== 32'h11) $display("FAIL lk_first got %h/%h want 00000080/11", OUT_WRITE, OUT_DATA); else pass_cnt++;
    total_cnt++; if (LOOKUP_DATA !== 32'h22) $display("FAIL lk_young got %h want 22", LOOKUP_DATA); else pass_cnt++;
    step();
    total_cnt++; if (OUT_WRITE !== 32'h80 || OUT_DATA !== 32'h22) $display("FAIL lk_second got %h/%h want 00000080/22", OUT_WRITE, OUT_DATA); else pass_cnt++;
    total_cnt++; if (LOOKUP_HIT !== 1'b1 || LOOKUP_DATA !== 32'h22) $display("FAIL lk_stage got %0b/%h want 1/22", LOOKUP_HIT, LOOKUP_DATA); else pass_cnt++;
    step();
    total_cnt++; if (LOOKUP_HIT !== 1'b0 || LOOKUP_DATA !== 32'h0) $display("FAIL lk_done got %0b/%h want 0/0", LOOKUP_HIT, LOOKUP_DATA); else pass_cnt++;
  endtask

  task automatic test_zero_discard();
    LOOKUP_ADDR = 5'd0;
    IN_VALID = 1'b1; IN_ADDR = 5'd0; IN_DATA = 32'h55;
    step();
    IN_VALID = 1'b0;
    total_cnt++; if (COUNT !== 3'd1) $display("FAIL z_count got %0d want 1", COUNT); else pass_cnt++;
    total_cnt++; if (LOOKUP_HIT !== 1'b0) $display("FAIL z_hit_q got %0b want 0", LOOKUP_HIT); else pass_cnt++;
    step();
    total_cnt++; if (COUNT !== 3'd0) $display("FAIL z_drained got %0d want 0", COUNT); else pass_cnt++;
    total_cnt++; if (OUT_WRITE !== 32'd0) $display("FAIL z_write got %h want 0", OUT_WRITE); else pass_cnt++;
    total_cnt++; if (OUT_DATA !== 32'h55) $display("FAIL z_data got %h want 55", OUT_DATA); else pass_cnt++;
    total_cnt++; if (LOOKUP_HIT !== 1'b0) $display("FAIL z_hit_s got %0b want 0", LOOKUP_HIT); else pass_cnt++;
    step();
    total_cnt++; if (OUT_WRITE !== 32'd0) $display("FAIL z_after got %h want 0", OUT_WRITE); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      IN_VALID = (i < 4); IN_ADDR = 5'(10 + i); IN_DATA = 32'hA0 + 32'(i);
      step();
      if (i > 0) begin
        total_cnt++; if (OUT_WRITE !== (32'd1 << (9 + i))) $display("FAIL b2b_write got %h want %h", OUT_WRITE, 32'd1 << (9 + i)); else pass_cnt++;
        total_cnt++; if (OUT_DATA !== 32'hA0 + 32'(i - 1)) $display("FAIL b2b_data got %h want %h", OUT_DATA, 32'hA0 + 32'(i - 1)); else pass_cnt++;
      end
      if (i < 4) begin
        total_cnt++; if (COUNT !== 3'd1 || IN_READY !== 1'b1) $display("FAIL b2b_count got %0d/%0b want 1/1", COUNT, IN_READY); else pass_cnt++;
      end
    end
    IN_VALID = 1'b0;
    total_cnt++; if (COUNT !== 3'd0) $display("FAIL b2b_end got %0d want 0", COUNT); else pass_cnt++;
  endtask

  task automatic test_reset_mid_drain();
    STALL_DRAIN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IN_VALID = 1'b1; IN_ADDR = 5'(20 + i); IN_DATA = 32'hC0 + 32'(i);
      step();
    end
    IN_VALID = 1'b0; STALL_DRAIN = 1'b0;
    step();
    total_cnt++; if (COUNT !== 3'd3 || OUT_WRITE !== 32'h0010_0000) $display("FAIL mid_pre got %0d/%h want 3/00100000", COUNT, OUT_WRITE); else pass_cnt++;
    #2 RST = 1'b0;
    #1;
    total_cnt++; if (OUT_WRITE !== 32'd0) $display("FAIL mid_write got %h want 0", OUT_WRITE); else pass_cnt++;
    total_cnt++; if (OUT_DATA !== 32'd0) $display("FAIL mid_data got %h want 0", OUT_DATA); else pass_cnt++;
    total_cnt++; if (COUNT !== 3'd0) $display("FAIL mid_count got %0d want 0", COUNT); else pass_cnt++;
    step();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (OUT_WRITE !== 32'd0 || COUNT !== 3'd0) $display("FAIL post_idle got %h/%0d want 0/0", OUT_WRITE, COUNT); else pass_cnt++;
    end
    IN_VALID = 1'b1; IN_ADDR = 5'd2; IN_DATA = 32'h77;
    step();
    IN_VALID = 1'b0;
    step();
    total_cnt++; if (OUT_WRITE !== 32'h4 || OUT_DATA !== 32'h77) $display("FAIL post_push got %h/%h want 4/77", OUT_WRITE, OUT_DATA); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_wrap();
    test_lookup();
    test_zero_discard();
    test_back_to_back();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
